// File: rtl/toy_fetch_filter_pkg.sv
// Shared types for the fetch filter: fetch-line beat, fetch-queue entry and
// the per-instruction entry builder used by the parcel walk.
package toy_fetch_filter_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned FILTER_CHANNEL   = 8;
  localparam int unsigned DEF_LINE_PARCELS = 8;
  localparam int unsigned DEF_PARCEL_IDX_W = $clog2(DEF_LINE_PARCELS);
  localparam int unsigned CH_W             = $clog2(FILTER_CHANNEL);
  localparam int unsigned CNT_W            = $clog2(FILTER_CHANNEL + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]         pc;
    logic [32-1:0]                 inst;
    logic                          is_cext;
    logic                          carry;
    logic [DEF_PARCEL_IDX_W-1:0]   offset;
    logic [ADDR_WIDTH-1:0]         pred_pc;
    logic                          taken;
    logic [ADDR_WIDTH-1:0]         tgt_pc;
    logic                          is_call;
    logic                          is_ret;
  } fetch_queue_pkg;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]          pc;
    logic [DEF_LINE_PARCELS*16-1:0] data;
    logic [DEF_PARCEL_IDX_W-1:0]    start_idx;
    logic [DEF_PARCEL_IDX_W-1:0]    end_idx;
    logic                           taken;
    logic [ADDR_WIDTH-1:0]          tgt_pc;
    logic                           is_call;
    logic                           is_ret;
  } fetch_line_pkg;

  // Branch info from the line applies only to the instruction covering line end.
  function automatic fetch_queue_pkg make_inst(
    input logic [ADDR_WIDTH-1:0]       pc,
    input logic [31:0]                 inst,
    input logic                        is_cext,
    input logic                        carry,
    input logic [DEF_PARCEL_IDX_W-1:0] offset,
    input logic                        last,
    input fetch_line_pkg               line
  );
    fetch_queue_pkg e;
    e.pc      = pc;
    e.inst    = inst;
    e.is_cext = is_cext;
    e.carry   = carry;
    e.offset  = offset;
    e.pred_pc = pc + (is_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
    e.taken   = last & line.taken;
    e.tgt_pc  = last ? line.tgt_pc : e.pred_pc;
    e.is_call = last & line.is_call;
    e.is_ret  = last & line.is_ret;
    return e;
  endfunction

endpackage

// File: rtl/toy_fetch_parcel_walk.sv
// Combinational walk over one fetch line: splits parcels into RV instructions,
// stitches a pending straddle half, packs the group and computes next carry.
module toy_fetch_parcel_walk
  import toy_fetch_filter_pkg::*;
(
  input  logic                      carry_vld,
  input  logic [15:0]               carry_lo,
  input  logic [ADDR_WIDTH-1:0]     carry_pc,
  input  fetch_line_pkg             line,
  output fetch_queue_pkg            grp [FILTER_CHANNEL],
  output logic [CNT_W-1:0]          grp_n,
  output logic [FILTER_CHANNEL-1:0] grp_en,
  output logic                      nxt_carry_vld,
  output logic [15:0]               nxt_carry_lo,
  output logic [ADDR_WIDTH-1:0]     nxt_carry_pc
);

  localparam int unsigned IW = DEF_PARCEL_IDX_W;

  always_comb begin
    logic [IW:0]           pos;
    logic [IW-1:0]         p;
    logic [15:0]           par;
    logic [15:0]           par_hi;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_W-1:0]      n;
    logic                  last;
    logic                  done;

    for (int unsigned c = 0; c < FILTER_CHANNEL; c++) grp[c] = '0;
    nxt_carry_vld = 1'b0;
    nxt_carry_lo  = carry_lo;
    nxt_carry_pc  = carry_pc;
    n             = '0;
    done          = 1'b0;
    last          = 1'b0;
    pos           = {1'b0, line.start_idx};

    // A carry with a non-zero start is dropped; the walk simply begins at start.
    if (carry_vld && line.start_idx == '0) begin
      last   = (line.end_idx == '0);
      grp[0] = make_inst(carry_pc, {line.data[15:0], carry_lo}, 1'b0, 1'b1,
                         IW'(DEF_LINE_PARCELS - 1), last, line);
      n      = CNT_W'(1);
      pos    = (IW+1)'(1);
      done   = last;
    end

    for (int unsigned i = 0; i < DEF_LINE_PARCELS; i++) begin
      p      = pos[IW-1:0];
      par    = line.data[{p, 4'b0000} +: 16];
      par_hi = line.data[{p + IW'(1), 4'b0000} +: 16];
      pc     = line.pc + ADDR_WIDTH'({p, 1'b0});
      last   = 1'b0;
      if (!done) begin
        if (pos >= (IW+1)'(DEF_LINE_PARCELS) || pos > {1'b0, line.end_idx}) begin
          done = 1'b1;
        end else if (par[1:0] != 2'b11) begin
          last = (p == line.end_idx);
          grp[n[CH_W-1:0]] = make_inst(pc, {16'h0000, par}, 1'b1, 1'b0, p, last, line);
          n   = n + CNT_W'(1);
          pos = pos + (IW+1)'(1);
        end else if (p == IW'(DEF_LINE_PARCELS - 1)) begin
          nxt_carry_vld = 1'b1;
          nxt_carry_lo  = par;
          nxt_carry_pc  = pc;
          done          = 1'b1;
        end else begin
          last = (p == line.end_idx) || ((p + IW'(1)) == line.end_idx);
          grp[n[CH_W-1:0]] = make_inst(pc, {par_hi, par}, 1'b0, 1'b0, p, last, line);
          n   = n + CNT_W'(1);
          pos = pos + (IW+1)'(2);
        end
        if (last) done = 1'b1;
      end
    end

    grp_n = n;
    for (int unsigned c = 0; c < FILTER_CHANNEL; c++) grp_en[c] = (CNT_W'(c) < n);
  end

endmodule

// File: rtl/toy_fetch_filter.sv
// Fetch-line filter/aligner: accepts a line, walks it into instructions and
// presents the packed group as one registered beat to the fetch queue.
module toy_fetch_filter
  import toy_fetch_filter_pkg::*;
#(
  parameter int unsigned LINE_PARCELS = DEF_LINE_PARCELS,
  parameter int unsigned PARCEL_IDX_W = $clog2(LINE_PARCELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cancel_en,
  input  logic                      line_vld,
  output logic                      line_rdy,
  input  logic [ADDR_WIDTH-1:0]     line_pc,
  input  logic [LINE_PARCELS*16-1:0] line_data,
  input  logic [PARCEL_IDX_W-1:0]   line_start,
  input  logic [PARCEL_IDX_W-1:0]   line_end,
  input  logic                      line_taken,
  input  logic [ADDR_WIDTH-1:0]     line_tgt_pc,
  input  logic                      line_is_call,
  input  logic                      line_is_ret,
  output logic                      filter_vld,
  input  logic                      filter_rdy,
  output fetch_queue_pkg            filter_pld [FILTER_CHANNEL],
  output logic [FILTER_CHANNEL-1:0] filter_en
);

  logic                      out_vld;
  logic                      carry_vld;
  logic [15:0]               carry_lo;
  logic [ADDR_WIDTH-1:0]     carry_pc;
  logic                      line_acc;
  fetch_line_pkg             line;
  fetch_queue_pkg            walk_grp [FILTER_CHANNEL];
  logic [CNT_W-1:0]          walk_n;
  logic [FILTER_CHANNEL-1:0] walk_en;
  logic                      walk_carry_vld;
  logic [15:0]               walk_carry_lo;
  logic [ADDR_WIDTH-1:0]     walk_carry_pc;

  assign line_rdy   = ~cancel_en & (~out_vld | filter_rdy);
  assign line_acc   = line_vld & line_rdy;
  assign filter_vld = out_vld;

  always_comb begin
    line           = '0;
    line.pc        = line_pc;
    line.data      = line_data;
    line.start_idx = line_start;
    line.end_idx   = line_end;
    line.taken     = line_taken;
    line.tgt_pc    = line_tgt_pc;
    line.is_call   = line_is_call;
    line.is_ret    = line_is_ret;
  end

  toy_fetch_parcel_walk u_walk (
    .carry_vld     (carry_vld),
    .carry_lo      (carry_lo),
    .carry_pc      (carry_pc),
    .line          (line),
    .grp           (walk_grp),
    .grp_n         (walk_n),
    .grp_en        (walk_en),
    .nxt_carry_vld (walk_carry_vld),
    .nxt_carry_lo  (walk_carry_lo),
    .nxt_carry_pc  (walk_carry_pc)
  );

  // A line that only loads the carry is consumed without producing a group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      filter_en <= '0;
      carry_vld <= 1'b0;
    end else if (cancel_en) begin
      out_vld   <= 1'b0;
      filter_en <= '0;
      carry_vld <= 1'b0;
    end else begin
      if (line_acc) carry_vld <= walk_carry_vld;
      if (line_acc && walk_n != '0) begin
        out_vld   <= 1'b1;
        filter_en <= walk_en;
      end else if (filter_rdy) begin
        out_vld   <= 1'b0;
        filter_en <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_acc && walk_n != '0) filter_pld <= walk_grp;
    if (line_acc && walk_carry_vld) begin
      carry_lo <= walk_carry_lo;
      carry_pc <= walk_carry_pc;
    end
  end

  a_no_start_with_carry: assert property (@(posedge clk) disable iff (!rst_n)
    (line_acc && carry_vld) |-> (line_start == '0));

endmodule

// File: tb/tb_toy_fetch_filter.sv
// Directed scoreboard bench for toy_fetch_filter.
module tb_toy_fetch_filter;
  import toy_fetch_filter_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      cancel_en;
  logic                      line_vld;
  logic                      line_rdy;
  logic [31:0]               line_pc;
  logic [127:0]              line_data;
  logic [2:0]                line_start;
  logic [2:0]                line_end;
  logic                      line_taken;
  logic [31:0]               line_tgt_pc;
  logic                      line_is_call;
  logic                      line_is_ret;
  logic                      filter_vld;
  logic                      filter_rdy;
  fetch_queue_pkg            filter_pld [FILTER_CHANNEL];
  logic [FILTER_CHANNEL-1:0] filter_en;

  int checks = 0;
  int errors = 0;
  logic [7:0]     exp_en_q [$];
  fetch_queue_pkg exp_inst_q [$];
  logic [127:0]   d;

  always #5 clk = ~clk;

  toy_fetch_filter #(.LINE_PARCELS(8), .PARCEL_IDX_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cancel_en    (cancel_en),
    .line_vld     (line_vld),
    .line_rdy     (line_rdy),
    .line_pc      (line_pc),
    .line_data    (line_data),
    .line_start   (line_start),
    .line_end     (line_end),
    .line_taken   (line_taken),
    .line_tgt_pc  (line_tgt_pc),
    .line_is_call (line_is_call),
    .line_is_ret  (line_is_ret),
    .filter_vld   (filter_vld),
    .filter_rdy   (filter_rdy),
    .filter_pld   (filter_pld),
    .filter_en    (filter_en)
  );

  function automatic fetch_queue_pkg mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic cext, input logic carry, input logic [2:0] off,
                                        input logic last, input logic tk, input logic [31:0] tgt,
                                        input logic call, input logic ret);
    fetch_queue_pkg e;
    e.pc      = pc;
    e.inst    = inst;
    e.is_cext = cext;
    e.carry   = carry;
    e.offset  = off;
    e.pred_pc = pc + (cext ? 32'd2 : 32'd4);
    e.taken   = last & tk;
    e.tgt_pc  = last ? tgt : e.pred_pc;
    e.is_call = last & call;
    e.is_ret  = last & ret;
    return e;
  endfunction

  function automatic logic [127:0] seq_data(input logic [15:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = {r[111:0], 16'(base + 16'(i * 16))};
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input fetch_queue_pkg obs, input fetch_queue_pkg exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic service();
    logic [7:0]     e;
    fetch_queue_pkg x;
    if (filter_vld && filter_rdy) begin
      chk1("group_expected", exp_en_q.size() != 0, 1'b1);
      if (exp_en_q.size() != 0) begin
        e = exp_en_q.pop_front();
        chk8("filter_en", filter_en, e);
        for (int c = 0; c < FILTER_CHANNEL; c++) begin
          if (e[c] && exp_inst_q.size() != 0) begin
            x = exp_inst_q.pop_front();
            chk_inst($sformatf("pld_ch%0d", c), filter_pld[c], x);
          end
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    service();
    @(negedge clk);
  endtask

  task automatic send_line(input logic [31:0] pc, input logic [127:0] data, input logic [2:0] st,
                           input logic [2:0] en, input logic tk, input logic [31:0] tgt,
                           input logic call, input logic ret);
    logic accepted;
    line_pc = pc; line_data = data; line_start = st; line_end = en;
    line_taken = tk; line_tgt_pc = tgt; line_is_call = call; line_is_ret = ret;
    line_vld = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      #1;
      accepted = line_rdy;
      service();
      @(negedge clk);
    end
    line_vld = 1'b0;
    chk1("line_accept_timeout", accepted, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_en_q.size() != 0; k++) tick();
    chk1("drain_timeout", exp_en_q.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cancel_en = 1'b0; line_vld = 1'b0; filter_rdy = 1'b1;
    line_pc = '0; line_data = '0; line_start = '0; line_end = '0;
    line_taken = 1'b0; line_tgt_pc = '0; line_is_call = 1'b0; line_is_ret = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("reset_filter_vld", filter_vld, 1'b0);
    chk8("reset_filter_en", filter_en, 8'h00);
    chk1("reset_line_rdy", line_rdy, 1'b1);
    chk1("reset_carry_vld", dut.carry_vld, 1'b0);
    @(negedge clk);

    // all 16-bit parcels
    exp_en_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++)
      exp_inst_q.push_back(mk(32'h1000 + 32'(2 * i), {16'h0, 16'h1001 + 16'(i * 16)}, 1'b1, 1'b0,
                              3'(i), i == 7, 1'b0, 32'h1010, 1'b0, 1'b0));
    send_line(32'h1000, seq_data(16'h1001), 3'd0, 3'd7, 1'b0, 32'h1010, 1'b0, 1'b0);

    // 32-bit at 0-1 and 6-7
    exp_en_q.push_back(8'h3F);
    exp_inst_q.push_back(mk(32'h2000, 32'h12340003, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    for (int i = 2; i < 6; i++)
      exp_inst_q.push_back(mk(32'h2000 + 32'(2 * i), {16'h0, 16'h2001 + 16'((i - 2) * 16)}, 1'b1,
                              1'b0, 3'(i), 1'b0, 1'b0, 0, 1'b0, 1'b0));
    exp_inst_q.push_back(mk(32'h200C, 32'hABCD0073, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 32'h2010, 1'b0, 1'b0));
    d = {16'hABCD, 16'h0073, 16'h2031, 16'h2021, 16'h2011, 16'h2001, 16'h1234, 16'h0003};
    send_line(32'h2000, d, 3'd0, 3'd7, 1'b0, 32'h2010, 1'b0, 1'b0);

    // straddle: line A leaves a carry, line B completes it
    exp_en_q.push_back(8'h7F);
    for (int i = 0; i < 7; i++)
      exp_inst_q.push_back(mk(32'h1000 + 32'(2 * i), {16'h0, 16'h3001 + 16'(i * 16)}, 1'b1, 1'b0,
                              3'(i), 1'b0, 1'b0, 0, 1'b0, 1'b0));
    d = seq_data(16'h3001);
    d[127:112] = 16'h0017;
    send_line(32'h1000, d, 3'd0, 3'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("straddle_carry_set", dut.carry_vld, 1'b1);

    exp_en_q.push_back(8'hFF);
    exp_inst_q.push_back(mk(32'h100E, 32'hBEEF0017, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    for (int i = 1; i < 8; i++)
      exp_inst_q.push_back(mk(32'h1010 + 32'(2 * i), {16'h0, 16'h4001 + 16'(i * 16)}, 1'b1, 1'b0,
                              3'(i), i == 7, 1'b0, 32'h1020, 1'b0, 1'b0));
    d = seq_data(16'h4001);
    d[15:0] = 16'hBEEF;
    send_line(32'h1010, d, 3'd0, 3'd7, 1'b0, 32'h1020, 1'b0, 1'b0);
    chk1("straddle_carry_clr", dut.carry_vld, 1'b0);

    // taken branch mid-line; parcel 7 looks like a 32-bit half but is past end
    exp_en_q.push_back(8'h03);
    exp_inst_q.push_back(mk(32'h3004, 32'h00004001, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    exp_inst_q.push_back(mk(32'h3006, 32'h56780063, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b0));
    d = {16'h00FF, 16'h0001, 16'h0001, 16'h5678, 16'h0063, 16'h4001, 16'h0001, 16'hFFFF};
    send_line(32'h3000, d, 3'd2, 3'd4, 1'b1, 32'h2000, 1'b1, 1'b0);
    chk1("taken_carry_clr", dut.carry_vld, 1'b0);
    drain();

    // empty walks: start past end, then a carry-only line
    send_line(32'h3100, seq_data(16'h0001), 3'd5, 3'd3, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("empty_no_group", filter_vld, 1'b0);
    d = seq_data(16'h0001);
    d[127:112] = 16'h002B;
    send_line(32'h4000, d, 3'd7, 3'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("carry_only_no_group", filter_vld, 1'b0);
    chk1("carry_only_carry", dut.carry_vld, 1'b1);

    exp_en_q.push_back(8'h01);
    exp_inst_q.push_back(mk(32'h400E, 32'hCAFE002B, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b1));
    d = seq_data(16'h0001);
    d[15:0]  = 16'hCAFE;
    d[31:16] = 16'h0003;
    send_line(32'h4010, d, 3'd0, 3'd0, 1'b1, 32'h5000, 1'b0, 1'b1);
    chk1("stitch_end0_carry_clr", dut.carry_vld, 1'b0);
    drain();

    // backpressure: X parked in the output, Y pending
    filter_rdy = 1'b0;
    exp_en_q.push_back(8'h03);
    exp_inst_q.push_back(mk(32'h6008, 32'h00005041, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    exp_inst_q.push_back(mk(32'h600A, 32'h00005051, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 32'h600C, 1'b0, 1'b0));
    send_line(32'h6000, seq_data(16'h5001), 3'd4, 3'd5, 1'b0, 32'h600C, 1'b0, 1'b0);
    exp_en_q.push_back(8'h01);
    exp_inst_q.push_back(mk(32'h6100, 32'h00007001, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h6102, 1'b0, 1'b0));
    d = seq_data(16'h7001);
    line_pc = 32'h6100; line_data = d; line_start = 3'd0; line_end = 3'd0;
    line_taken = 1'b0; line_tgt_pc = 32'h6102; line_is_call = 1'b0; line_is_ret = 1'b0;
    line_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("hold_line_rdy", line_rdy, 1'b0);
      chk1("hold_filter_vld", filter_vld, 1'b1);
      chk8("hold_filter_en", filter_en, 8'h03);
      chk_inst("hold_pld_ch0", filter_pld[0],
               mk(32'h6008, 32'h00005041, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0));
      chk_inst("hold_pld_ch1", filter_pld[1],
               mk(32'h600A, 32'h00005051, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 32'h600C, 1'b0, 1'b0));
      @(negedge clk);
    end
    filter_rdy = 1'b1;
    send_line(32'h6100, d, 3'd0, 3'd0, 1'b0, 32'h6102, 1'b0, 1'b0);
    drain();

    // cancel with a group parked, a carry pending and a line offered
    filter_rdy = 1'b0;
    d = seq_data(16'h6001);
    d[127:112] = 16'h0007;
    send_line(32'h7000, d, 3'd6, 3'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    chk1("pre_cancel_vld", filter_vld, 1'b1);
    chk8("pre_cancel_en", filter_en, 8'h01);
    chk1("pre_cancel_carry", dut.carry_vld, 1'b1);
    d = seq_data(16'h8001);
    line_pc = 32'h7010; line_data = d; line_start = 3'd0; line_end = 3'd1;
    line_taken = 1'b0; line_tgt_pc = 32'h7014; line_vld = 1'b1;
    cancel_en = 1'b1;
    #1;
    chk1("cancel_line_rdy", line_rdy, 1'b0);
    @(negedge clk);
    cancel_en = 1'b0;
    #1;
    chk1("cancel_filter_vld", filter_vld, 1'b0);
    chk8("cancel_filter_en", filter_en, 8'h00);
    chk1("cancel_carry_vld", dut.carry_vld, 1'b0);
    exp_en_q.push_back(8'h03);
    exp_inst_q.push_back(mk(32'h7010, 32'h00008001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    exp_inst_q.push_back(mk(32'h7012, 32'h00008011, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h7014, 1'b0, 1'b0));
    filter_rdy = 1'b1;
    send_line(32'h7010, d, 3'd0, 3'd1, 1'b0, 32'h7014, 1'b0, 1'b0);
    drain();
    tick();
    tick();
    chk1("final_no_extra_group", filter_vld, 1'b0);
    chk1("final_inst_queue_empty", exp_inst_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toy_fetch_filter.md
# toy_fetch_filter

Instruction filter/aligner between the fetch-line source (I-cache data plus branch-prediction result) and the fetch queue. Each accepted fetch line of 16-bit parcels is split into up to FILTER_CHANNEL RV instructions (16-bit compressed or 32-bit). Instructions straddling a line boundary are stitched using a carry register. The packed group is presented in one registered beat on the filter_* handshake, which the fetch queue consumes.

## Interface
- LINE_PARCELS, default 8: 16-bit parcels per fetch line. Must be ≤ FILTER_CHANNEL.
- PARCEL_IDX_W, default $clog2(LINE_PARCELS): width of parcel indices.
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- cancel_en, input, 1: pipeline flush, same net as the fetch queue's.
- line_vld, input, 1: fetch line valid.
- line_rdy, output, 1: filter can accept a line.
- line_pc, input, ADDR_WIDTH: byte PC of parcel 0; line-aligned.
- line_data, input, LINE_PARCELS*16: parcels; parcel p is at bits [16p+15:16p].
- line_start, input, PARCEL_IDX_W: first parcel to execute. 0 for sequential lines.
- line_end, input, PARCEL_IDX_W: last parcel of the fetch block.
- line_taken, input, 1: the instruction covering line_end is predicted taken.
- line_tgt_pc, input, ADDR_WIDTH: predicted target.
- line_is_call / line_is_ret, input, 1 each: RAS hints for the taken instruction.
- filter_vld, output, 1: group valid.
- filter_rdy, input, 1: fetch queue ready.
- filter_pld, output, fetch_queue_pkg [FILTER_CHANNEL]: packed instructions.
- filter_en, output, FILTER_CHANNEL: per-channel valid. Always contiguous from bit 0.

## Operation
- Output register holds one group (out_vld).
- line_rdy = ~cancel_en & (~out_vld | filter_rdy).
- A line is accepted when line_vld & line_rdy.
- Walk (combinational, over accepted line):
  - If carry_vld: emit stitched instruction, {parcel0, carry_lo}. pc = carry_pc, is_cext=0, carry=1, offset=LINE_PARCELS-1. Walk continues at parcel 1.
  - If carry_vld and line_start≠0: carry is dropped and the walk begins at line_start. This is an illegal sequence and is covered by an assertion.
  - Otherwise the walk begins at line_start.
  - At parcel p, if data[1:0]≠2'b11: 16-bit instruction. inst={16'b0,parcel}, is_cext=1, next p+1.
  - At parcel p, if data[1:0]=2'b11 and p<LINE_PARCELS-1: 32-bit instruction {parcel p+1, parcel p}, is_cext=0, next p+2.
  - At parcel p, if data[1:0]=2'b11 and p=LINE_PARCELS-1: not emitted. Load carry_lo=parcel, carry_pc=line_pc+2p, carry_vld=1.
  - The walk stops after the instruction whose parcel range contains line_end. Parcels beyond line_end are ignored.
  - carry_vld is set only if the walk reached parcel LINE_PARCELS-1 as a 32-bit first half. Otherwise it is cleared on acceptance.
- Per emitted instruction:
  - pc = line_pc + 2*p (modulo ADDR_WIDTH).
  - offset = p.
  - pred_pc = pc + (is_cext ? 2 : 4).
  - taken, tgt_pc, is_call, is_ret are taken from line_* only on the instruction covering line_end. Otherwise taken=0, tgt_pc=pred_pc, is_call=is_ret=0.
- Packing: instructions fill channels 0..n-1 in program order, and filter_en = (1<<n)-1.
- If n=0 (the line only loads the carry, or line_start>line_end): the line is consumed and out_vld is not set.
- Cancel: out_vld, filter_en and carry_vld are cleared next edge. A line presented in the cancel cycle is not accepted.

## Timing
- Latency: a line accepted at edge k gives filter_vld=1 from edge k onward (registered, one cycle after the line_vld cycle).
- Throughput: one line per cycle while filter_rdy=1.
- Hold: filter_vld, filter_pld and filter_en hold stable while filter_vld & ~filter_rdy.
- Reset values:
  - filter_vld=0, filter_en=0, carry_vld=0.
  - line_rdy=1 after reset.
  - filter_pld and carry_lo/carry_pc are not reset.
- Simultaneous output handshake and new line accept: the output register reloads in the same edge, with no bubble.
- cancel_en has priority over all updates.

## Structure
- toy_pack gains LINE_PARCELS and fetch_line_pkg (pc, data, start, end, taken, tgt_pc, is_call, is_ret).
- fetch_queue_pkg is reused unchanged.
- One sub-module, toy_fetch_parcel_walk: a purely combinational walk and pack. It takes carry state plus the line, and produces the packed group, n, and next-carry.
- The top level keeps the registers and the handshake.

## Test plan
- Sequential line, line_pc=0x1000, all 16-bit parcels, start=0, end=7 → filter_en=8'hFF. pcs are 0x1000..0x100E step 2, all is_cext=1.
- Line with parcels 0,1 forming one 32-bit instruction, 2–5 16-bit, and 6,7 forming one 32-bit instruction → filter_en=8'h3F. offsets 0,2,3,4,5,6.
- Straddle: line A has 16-bit parcels 0–6 and parcel 7 with [1:0]=11 → 7 instructions, carry_vld=1. Line B at 0x1010, parcel 0 completes the straddle → channel 0 has pc=0x100E, carry=1, offset=7.
- Taken branch: start=2, end=4 with a 32-bit instruction at 3–4, taken, tgt=0x2000 → filter_en=8'h03. Channel 1 has taken=1, tgt_pc=0x2000; carry_vld=0.
- Backpressure: filter_rdy=0 for 3 cycles with lines pending → line_rdy=0, outputs stable. When filter_rdy rises, one group is consumed per cycle and no line is lost or duplicated.
- cancel_en asserted with out_vld=1, carry_vld=1 and line_vld=1 → next cycle filter_vld=0, carry_vld=0, and that line is not consumed.
